stage_sequencer_arbiter: RTL and testbench
==========================================

// Module: stage_sequencer_arbiter
// PURPOSE
//  Parametrised successor to the fixed three-stage evaluator control: fetches NUM_INIT_VAL initial values from
//  state-variable memory, then runs up to NUM_STAGES sub-blocks in order (angle comb, normalization, term acc, ...).
//  Time-multiplexes NUM_UNITS shared FP units (add/mult/div/exp) onto the active stage and writes the final result
//  back to state-variable memory. Adds a per-run stage-skip mask, a per-stage watchdog, abort and error reporting.
// PARAMETERS
//  DATA_WIDTH     32     FP word width
//  NUM_INIT_VAL   6      init values fetched per run
//  NUM_EVAL_VAL   3      result slots; state-var memory depth = NUM_INIT_VAL+NUM_EVAL_VAL
//  NUM_STAGES     3      sequenced sub-blocks, run in index order 0..NUM_STAGES-1
//  NUM_UNITS      5      shared FP units (operand pair + start + result + ready each)
//  TIMEOUT_CYCLES 65535  max STAGE_WAIT cycles per stage before error
// PORTS (AW = $clog2(NUM_INIT_VAL+NUM_EVAL_VAL), SW = $clog2(NUM_STAGES))
//  clock            in   1                    single clock, rising edge
//  reset            in   1                    asynchronous, active-high
//  start            in   1                    run request, sampled in IDLE/ERROR only
//  abort            in   1                    cancel run, return to IDLE
//  stage_en_mask    in   NUM_STAGES           latched at start; bit=0 skips the stage
//  eval_idx         in   $clog2(NUM_EVAL_VAL) latched at start; result slot
//  mem_rd_addr      out  AW                   state-var read address (1-cycle read latency)
//  mem_rd_data      in   DATA_WIDTH           state-var read data
//  mem_wr_addr      out  AW                   state-var write address
//  mem_wr_data      out  DATA_WIDTH           state-var write data
//  mem_wr_en        out  1                    state-var write strobe
//  init_val_flat    out  NUM_INIT_VAL*DW      fetched init values, entry i at [i*DW +: DW]
//  stage_start      out  NUM_STAGES           one-cycle start pulse per stage
//  stage_done       in   NUM_STAGES           stage completion pulse
//  stage_result     in   DATA_WIDTH           result from last enabled stage, valid with its done
//  stage_op_a/op_b  in   NUM_STAGES*NUM_UNITS*DW  per-stage unit operands, [(s*NUM_UNITS+u)*DW +: DW]
//  stage_op_start   in   NUM_STAGES*NUM_UNITS per-stage unit start requests
//  stage_unit_ready out  NUM_STAGES*NUM_UNITS unit ready, gated to active stage
//  unit_a/unit_b    out  NUM_UNITS*DW         operands to shared units
//  unit_start       out  NUM_UNITS            start to shared units
//  unit_ready       in   NUM_UNITS            unit result valid; unit results go direct to stages (not via here)
//  busy             out  1                    high in every state except IDLE/ERROR
//  done             out  1                    one-cycle pulse, run completed OK
//  err              out  1                    sticky until next start/abort
//  err_code         out  2                    0 none, 1 timeout, 2 bad eval_idx
//  err_stage        out  SW                   stage index at timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, init values cleared, counters 0.
//  - States: IDLE, FETCH, STAGE_START, STAGE_WAIT, WRITEBACK, DONE, ERROR.
//  - IDLE/ERROR + start: latch mask/eval_idx, clear err/err_code, go FETCH. start while busy ignored.
//  - FETCH: mem_rd_addr = 0..NUM_INIT_VAL-1 on consecutive cycles, data captured 1 cycle later into entry addr;
//    exactly NUM_INIT_VAL+1 cycles, then STAGE_START with stage ptr=0.
//  - STAGE_START: if mask[ptr] then pulse stage_start[ptr] 1 cycle, clear watchdog, go STAGE_WAIT;
//    else skip (1 cycle, no pulse) to next ptr. After last ptr go WRITEBACK.
//  - STAGE_WAIT: unit_a/b/start[u] = stage_op_*[ptr][u]; stage_unit_ready[ptr][u]=unit_ready[u], others 0.
//    All other states: unit_start=0, operands 0. Routing is combinational, zero latency.
//    stage_done[ptr] -> latch stage_result, ptr+1, STAGE_START. done of non-active stage ignored.
//    watchdog == TIMEOUT_CYCLES-1 without done -> ERROR, err_code=1, err_stage=ptr. Done and timeout same cycle: done wins.
//  - WRITEBACK (1 cycle): if eval_idx<NUM_EVAL_VAL, mem_wr_en=1, addr=NUM_INIT_VAL+eval_idx, data=latched result, go DONE;
//    else no write, ERROR with err_code=2. All-zero mask: writes 0.
//  - DONE: done=1 for one cycle, go IDLE.
//  - abort (any state except IDLE): next state IDLE, no done, no write, err cleared; abort has priority over all.
//  - Async reset mid-run: immediate return to reset values, no pending start/write pulse survives.
// TESTING
//  - Mem 0..5 = 1.0..6.0, mask=3'b111, stages done after 10 cycles, result 0x40490FDB, eval_idx=1 -> init_val_flat matches, mem[7]=0x40490FDB, done 1 cycle.
//  - mask=3'b101 -> stage_start[1] never pulses; stage 2 result written; total cycles = full run - stage1 time.
//  - Stage1 drives unit 0 op_start with a=0x3F800000 -> unit_start[0]=1 only while stage1 active; stage0/2 ready=0.
//  - TIMEOUT_CYCLES=16, stage 1 never done -> err=1, err_code=1, err_stage=1 at cycle 16 of wait; no write.
//  - eval_idx=3 (NUM_EVAL_VAL=3) -> err_code=2, mem_wr_en never high; next start clears err.
//  - abort in STAGE_WAIT, and reset mid-FETCH -> IDLE next cycle/immediately, unit_start=0, done=0, mem_wr_en=0.

Source files
------------

// File: rtl/stage_sequencer_arbiter.sv
// Run controller for the evaluator: fetches the init values, sequences the enabled stages in order,
// lends the shared FP units to whichever stage is active and writes the final result back.
module stage_sequencer_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_INIT_VAL   = 6,
   parameter int NUM_EVAL_VAL   = 3,
   parameter int NUM_STAGES     = 3,
   parameter int NUM_UNITS      = 5,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          start,
   input  logic                                          abort,
   input  logic [NUM_STAGES-1:0]                         stage_en_mask,
   input  logic [$clog2(NUM_EVAL_VAL)-1:0]               eval_idx,
   output logic [$clog2(NUM_INIT_VAL+NUM_EVAL_VAL)-1:0]  mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]                         mem_rd_data,
   output logic [$clog2(NUM_INIT_VAL+NUM_EVAL_VAL)-1:0]  mem_wr_addr,
   output logic [DATA_WIDTH-1:0]                         mem_wr_data,
   output logic                                          mem_wr_en,
   output logic [NUM_INIT_VAL*DATA_WIDTH-1:0]            init_val_flat,
   output logic [NUM_STAGES-1:0]                         stage_start,
   input  logic [NUM_STAGES-1:0]                         stage_done,
   input  logic [DATA_WIDTH-1:0]                         stage_result,
   input  logic [NUM_STAGES*NUM_UNITS*DATA_WIDTH-1:0]    stage_op_a,
   input  logic [NUM_STAGES*NUM_UNITS*DATA_WIDTH-1:0]    stage_op_b,
   input  logic [NUM_STAGES*NUM_UNITS-1:0]               stage_op_start,
   output logic [NUM_STAGES*NUM_UNITS-1:0]               stage_unit_ready,
   output logic [NUM_UNITS*DATA_WIDTH-1:0]               unit_a,
   output logic [NUM_UNITS*DATA_WIDTH-1:0]               unit_b,
   output logic [NUM_UNITS-1:0]                          unit_start,
   input  logic [NUM_UNITS-1:0]                          unit_ready,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          err,
   output logic [1:0]                                    err_code,
   output logic [$clog2(NUM_STAGES)-1:0]                 err_stage
);

   localparam int AW = $clog2(NUM_INIT_VAL+NUM_EVAL_VAL);
   localparam int EW = $clog2(NUM_EVAL_VAL);
   localparam int SW = $clog2(NUM_STAGES);
   localparam int PW = SW + 1;
   localparam int IW = $clog2(NUM_INIT_VAL);
   localparam int FW = $clog2(NUM_INIT_VAL+1);
   localparam int WW = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [PW-1:0] PTR_END    = PW'(NUM_STAGES);
   localparam logic [FW-1:0] FETCH_LAST = FW'(NUM_INIT_VAL);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES-1);
   localparam logic [AW-1:0] RES_BASE   = AW'(NUM_INIT_VAL);
   localparam logic [EW:0]   EVAL_LIM   = (EW+1)'(NUM_EVAL_VAL);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_STAGE_START, ST_STAGE_WAIT, ST_WRITEBACK, ST_DONE, ST_ERROR
   } state_t;

   state_t                 state, state_next;
   logic [FW-1:0]          fetch_cnt;
   logic [DATA_WIDTH-1:0]  init_val [NUM_INIT_VAL];
   logic [PW-1:0]          ptr;
   logic [SW-1:0]          cur;
   logic [WW-1:0]          wd_cnt;
   logic [NUM_STAGES-1:0]  mask_q;
   logic [EW-1:0]          eval_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic                   eval_ok;
   logic                   abort_run;

   // ptr runs one past the last stage so STAGE_START can tell when the sequence is exhausted
   assign cur       = ptr[SW-1:0];
   assign eval_ok   = ({1'b0, eval_q} < EVAL_LIM);
   assign abort_run = abort && (state != ST_IDLE);

   for (genvar i = 0; i < NUM_INIT_VAL; i++) begin : g_init
      assign init_val_flat[i*DATA_WIDTH +: DATA_WIDTH] = init_val[i];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:        if (start) state_next = ST_FETCH;
         ST_FETCH:       if (fetch_cnt == FETCH_LAST) state_next = ST_STAGE_START;
         ST_STAGE_START: begin
            if (ptr == PTR_END)  state_next = ST_WRITEBACK;
            else if (mask_q[cur]) state_next = ST_STAGE_WAIT;
         end
         ST_STAGE_WAIT: begin
            if (stage_done[cur])        state_next = ST_STAGE_START;
            else if (wd_cnt == WD_LAST) state_next = ST_ERROR;
         end
         ST_WRITEBACK:   state_next = eval_ok ? ST_DONE : ST_ERROR;
         ST_DONE:        state_next = ST_IDLE;
         ST_ERROR:       if (start) state_next = ST_FETCH;
         default:        state_next = ST_IDLE;
      endcase
      if (abort_run) state_next = ST_IDLE;
   end

   // A completing stage beats the watchdog when both land on the same cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
         ptr       <= '0;
         wd_cnt    <= '0;
         mask_q    <= '0;
         eval_q    <= '0;
         result_q  <= '0;
         err       <= 1'b0;
         err_code  <= 2'd0;
         err_stage <= '0;
         for (int i = 0; i < NUM_INIT_VAL; i++) init_val[i] <= '0;
      end else if (abort_run) begin
         err       <= 1'b0;
         err_code  <= 2'd0;
         err_stage <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_ERROR: begin
               if (start) begin
                  mask_q    <= stage_en_mask;
                  eval_q    <= eval_idx;
                  fetch_cnt <= '0;
                  ptr       <= '0;
                  result_q  <= '0;
                  err       <= 1'b0;
                  err_code  <= 2'd0;
                  err_stage <= '0;
               end
            end
            ST_FETCH: begin
               fetch_cnt <= fetch_cnt + FW'(1);
               if (fetch_cnt != '0) init_val[IW'(fetch_cnt - FW'(1))] <= mem_rd_data;
            end
            ST_STAGE_START: begin
               if (ptr != PTR_END) begin
                  if (mask_q[cur]) wd_cnt <= '0;
                  else             ptr    <= ptr + PW'(1);
               end
            end
            ST_STAGE_WAIT: begin
               if (stage_done[cur]) begin
                  result_q <= stage_result;
                  ptr      <= ptr + PW'(1);
               end else if (wd_cnt == WD_LAST) begin
                  err       <= 1'b1;
                  err_code  <= 2'd1;
                  err_stage <= cur;
               end else begin
                  wd_cnt <= wd_cnt + WW'(1);
               end
            end
            ST_WRITEBACK: begin
               if (!eval_ok) begin
                  err      <= 1'b1;
                  err_code <= 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

   // Unit operands and readies are steered combinationally, so a stage sees no extra latency
   always_comb begin
      busy             = (state != ST_IDLE) && (state != ST_ERROR);
      done             = 1'b0;
      mem_rd_addr      = '0;
      mem_wr_addr      = '0;
      mem_wr_data      = '0;
      mem_wr_en        = 1'b0;
      stage_start      = '0;
      stage_unit_ready = '0;
      unit_a           = '0;
      unit_b           = '0;
      unit_start       = '0;
      case (state)
         ST_FETCH: begin
            if (fetch_cnt != FETCH_LAST) mem_rd_addr = AW'(fetch_cnt);
         end
         ST_STAGE_START: begin
            if ((ptr != PTR_END) && mask_q[cur] && !abort_run) stage_start[cur] = 1'b1;
         end
         ST_STAGE_WAIT: begin
            for (int u = 0; u < NUM_UNITS; u++) begin
               unit_a[u*DATA_WIDTH +: DATA_WIDTH] =
                  stage_op_a[(int'(cur)*NUM_UNITS + u)*DATA_WIDTH +: DATA_WIDTH];
               unit_b[u*DATA_WIDTH +: DATA_WIDTH] =
                  stage_op_b[(int'(cur)*NUM_UNITS + u)*DATA_WIDTH +: DATA_WIDTH];
               unit_start[u] = stage_op_start[int'(cur)*NUM_UNITS + u];
               stage_unit_ready[int'(cur)*NUM_UNITS + u] = unit_ready[u];
            end
         end
         ST_WRITEBACK: begin
            if (eval_ok && !abort_run) begin
               mem_wr_en   = 1'b1;
               mem_wr_addr = RES_BASE + AW'(eval_q);
               mem_wr_data = result_q;
            end
         end
         ST_DONE: done = !abort_run;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stage_sequencer_arbiter.sv
// Scoreboard bench for stage_sequencer_arbiter: directed runs push expected writes/done/errors,
// a negedge monitor pops and compares them; direct checks cover routing, timing and reset.
module tb_stage_sequencer_arbiter;

   localparam int DW  = 32;
   localparam int NI  = 6;
   localparam int NE  = 3;
   localparam int NS  = 3;
   localparam int NU  = 5;
   localparam int TMO = 16;
   localparam int EV_WR   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      bit          b_care;
   } ev_t;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic                  abort = 1'b0;
   logic [NS-1:0]         stage_en_mask = '0;
   logic [1:0]            eval_idx = '0;
   logic [3:0]            mem_rd_addr;
   logic [DW-1:0]         mem_rd_data;
   logic [3:0]            mem_wr_addr;
   logic [DW-1:0]         mem_wr_data;
   logic                  mem_wr_en;
   logic [NI*DW-1:0]      init_val_flat;
   logic [NS-1:0]         stage_start;
   logic [NS-1:0]         stage_done = '0;
   logic [DW-1:0]         stage_result = '0;
   logic [NS*NU*DW-1:0]   stage_op_a = '0;
   logic [NS*NU*DW-1:0]   stage_op_b = '0;
   logic [NS*NU-1:0]      stage_op_start = '0;
   logic [NS*NU-1:0]      stage_unit_ready;
   logic [NU*DW-1:0]      unit_a;
   logic [NU*DW-1:0]      unit_b;
   logic [NU-1:0]         unit_start;
   logic [NU-1:0]         unit_ready = '0;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [1:0]            err_code;
   logic [1:0]            err_stage;

   logic [31:0] mem [9];
   logic [31:0] init_exp [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                                 32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] stage_res [3] = '{32'h11111111, 32'h22222222, 32'h40490FDB};
   logic [NS-1:0] resp_en = 3'b111;
   ev_t  exp_q [$];
   int   total_cnt = 0;
   int   bad_cnt = 0;
   int   busy_cnt = 0;
   int   st_cnt [3] = '{0, 0, 0};
   logic err_prev = 1'b0;

   stage_sequencer_arbiter #(
      .DATA_WIDTH(DW), .NUM_INIT_VAL(NI), .NUM_EVAL_VAL(NE),
      .NUM_STAGES(NS), .NUM_UNITS(NU), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .stage_en_mask(stage_en_mask), .eval_idx(eval_idx),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
      .init_val_flat(init_val_flat), .stage_start(stage_start), .stage_done(stage_done),
      .stage_result(stage_result), .stage_op_a(stage_op_a), .stage_op_b(stage_op_b),
      .stage_op_start(stage_op_start), .stage_unit_ready(stage_unit_ready),
      .unit_a(unit_a), .unit_b(unit_b), .unit_start(unit_start), .unit_ready(unit_ready),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .err_stage(err_stage)
   );

   always #5 clock = ~clock;

   // State-variable memory with one cycle of read latency
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) mem[i] <= (i < 6) ? init_exp[i] : 32'h0;
         mem_rd_data <= '0;
      end else begin
         mem_rd_data <= mem[mem_rd_addr];
         if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      end
   end

   // Stage model: answers a start pulse with a done pulse on the 10th following cycle
   initial begin
      int pend_cnt;
      int pend_s;
      pend_cnt = 0;
      pend_s = 0;
      forever begin
         @(negedge clock);
         stage_done = '0;
         stage_result = '0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               stage_done = NS'(1) << pend_s;
               stage_result = stage_res[pend_s];
            end
         end else begin
            for (int s = 0; s < NS; s++)
               if (stage_start[s] && resp_en[s]) begin
                  pend_s = s;
                  pend_cnt = 10;
               end
         end
      end
   end

   always @(negedge clock) begin
      if (busy) busy_cnt++;
      for (int s = 0; s < NS; s++) if (stage_start[s]) st_cnt[s]++;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
      end
   endtask

   task automatic scoreEvent(input int kind, input logic [31:0] a, input logic [31:0] b);
      ev_t e;
      if (exp_q.size() == 0) begin
         total_cnt++;
         bad_cnt++;
         $display("[TB] FAIL unexpected_event: got kind=%0d a=%0h b=%0h required no event", kind, a, b);
      end else begin
         e = exp_q.pop_front();
         checkOutput("event_kind", 64'(kind), 64'(e.kind));
         if (kind == e.kind) begin
            checkOutput("event_a", 64'(a), 64'(e.a));
            if (e.b_care) checkOutput("event_b", 64'(b), 64'(e.b));
         end
      end
   endtask

   always @(negedge clock) begin
      if (mem_wr_en) scoreEvent(EV_WR, 32'(mem_wr_addr), mem_wr_data);
      if (done) scoreEvent(EV_DONE, 32'h0, 32'h0);
      if (err && !err_prev) scoreEvent(EV_ERR, 32'(err_code), 32'(err_stage));
      err_prev = err;
   end

   task automatic pushExp(input int kind, input logic [31:0] a, input logic [31:0] b, input bit care);
      ev_t e;
      e.kind = kind;
      e.a = a;
      e.b = b;
      e.b_care = care;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [NS-1:0] mask, input logic [1:0] eidx);
      @(negedge clock);
      stage_en_mask = mask;
      eval_idx = eidx;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic waitStageStart(input int s, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!stage_start[s] && n < 80);
      if (!stage_start[s]) begin
         total_cnt++;
         bad_cnt++;
         $display("[TB] FAIL %s: got no stage_start[%0d] within %0d cycles, required a pulse", name, s, n);
      end
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 200);
      if (!done) begin
         total_cnt++;
         bad_cnt++;
         $display("[TB] FAIL %s: got no done within %0d cycles, required done", name, n);
      end
   endtask

   task automatic waitErr(input string name, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!err && n < 80);
      if (!err) begin
         total_cnt++;
         bad_cnt++;
         $display("[TB] FAIL %s: got err=0 after %0d cycles, required err=1", name, n);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, required finish");
      $fatal(1, "[TB] bench timeout");
   end

   initial begin
      int base;
      int s0;
      int s1;
      int n;

      repeat (2) @(negedge clock);
      checkOutput("rst_busy", 64'(busy), 64'h0);
      checkOutput("rst_done", 64'(done), 64'h0);
      checkOutput("rst_err", 64'(err), 64'h0);
      checkOutput("rst_err_code", 64'(err_code), 64'h0);
      checkOutput("rst_wr_en", 64'(mem_wr_en), 64'h0);
      checkOutput("rst_stage_start", 64'(stage_start), 64'h0);
      checkOutput("rst_unit_start", 64'(unit_start), 64'h0);
      checkOutput("rst_rd_addr", 64'(mem_rd_addr), 64'h0);
      checkOutput("rst_init_vals", 64'(|init_val_flat), 64'h0);
      checkOutput("rst_unit_ready", 64'(stage_unit_ready), 64'h0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Full run with unit routing observed in stages 0 and 1
      unit_ready = 5'b00001;
      stage_op_start = 15'h0020;
      stage_op_a[5*DW +: DW] = 32'h3F800000;
      stage_op_b[5*DW +: DW] = 32'h40000000;
      pushExp(EV_WR, 32'd7, 32'h40490FDB, 1'b1);
      pushExp(EV_DONE, 32'h0, 32'h0, 1'b0);
      base = busy_cnt;
      applyStimulus(3'b111, 2'd1);
      waitStageStart(0, "full_stage0_start");
      @(negedge clock);
      checkOutput("s0_unit_start", 64'(unit_start), 64'h0);
      checkOutput("s0_unit_ready", 64'(stage_unit_ready), 64'h0001);
      checkOutput("s0_unit_a", 64'(unit_a[DW-1:0]), 64'h0);
      waitStageStart(1, "full_stage1_start");
      @(negedge clock);
      checkOutput("s1_unit_start", 64'(unit_start), 64'h01);
      checkOutput("s1_unit_a", 64'(unit_a[DW-1:0]), 64'h3F800000);
      checkOutput("s1_unit_b", 64'(unit_b[DW-1:0]), 64'h40000000);
      checkOutput("s1_unit_ready", 64'(stage_unit_ready), 64'h0020);
      waitDone("full_done");
      @(negedge clock);
      checkOutput("full_done_one_cycle", 64'(done), 64'h0);
      checkOutput("full_busy_cycles", 64'(busy_cnt - base), 64'd43);
      checkOutput("full_mem7", 64'(mem[7]), 64'h40490FDB);
      for (int i = 0; i < NI; i++)
         checkOutput($sformatf("init_val%0d", i), 64'(init_val_flat[i*DW +: DW]), 64'(init_exp[i]));
      checkOutput("idle_unit_start", 64'(unit_start), 64'h0);

      // Stage 1 skipped by mask
      stage_res[2] = 32'h402DF854;
      pushExp(EV_WR, 32'd8, 32'h402DF854, 1'b1);
      pushExp(EV_DONE, 32'h0, 32'h0, 1'b0);
      base = busy_cnt;
      s0 = st_cnt[0];
      s1 = st_cnt[1];
      applyStimulus(3'b101, 2'd2);
      waitDone("skip_done");
      @(negedge clock);
      checkOutput("skip_busy_cycles", 64'(busy_cnt - base), 64'd33);
      checkOutput("skip_stage1_pulses", 64'(st_cnt[1] - s1), 64'd0);
      checkOutput("skip_stage0_pulses", 64'(st_cnt[0] - s0), 64'd1);

      // Stage 1 never answers: watchdog fires after 16 wait cycles
      resp_en = 3'b101;
      pushExp(EV_ERR, 32'd1, 32'd1, 1'b1);
      applyStimulus(3'b111, 2'd0);
      waitStageStart(1, "tmo_stage1_start");
      waitErr("tmo_err", n);
      checkOutput("tmo_cycles", 64'(n), 64'd17);
      checkOutput("tmo_err_code", 64'(err_code), 64'd1);
      checkOutput("tmo_err_stage", 64'(err_stage), 64'd1);
      checkOutput("tmo_busy", 64'(busy), 64'h0);
      resp_en = 3'b111;
      repeat (3) @(negedge clock);
      checkOutput("tmo_err_sticky", 64'(err), 64'h1);

      // Out-of-range result slot, then a clean all-skip run clears the error
      pushExp(EV_ERR, 32'd2, 32'd0, 1'b0);
      applyStimulus(3'b000, 2'd3);
      checkOutput("bad_idx_err_cleared", 64'(err), 64'h0);
      waitErr("bad_idx_err", n);
      checkOutput("bad_idx_err_code", 64'(err_code), 64'd2);
      pushExp(EV_WR, 32'd6, 32'h0, 1'b1);
      pushExp(EV_DONE, 32'h0, 32'h0, 1'b0);
      base = busy_cnt;
      applyStimulus(3'b000, 2'd0);
      checkOutput("restart_err_cleared", 64'(err), 64'h0);
      checkOutput("restart_err_code", 64'(err_code), 64'h0);
      waitDone("zero_mask_done");
      @(negedge clock);
      checkOutput("zero_mask_busy_cycles", 64'(busy_cnt - base), 64'd13);

      // Abort while stage 0 holds the units
      stage_op_start = 15'h0021;
      applyStimulus(3'b111, 2'd0);
      waitStageStart(0, "abort_stage0_start");
      @(negedge clock);
      checkOutput("abort_pre_unit_start", 64'(unit_start), 64'h01);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'h0);
      checkOutput("abort_unit_start", 64'(unit_start), 64'h0);
      checkOutput("abort_done", 64'(done), 64'h0);
      checkOutput("abort_wr_en", 64'(mem_wr_en), 64'h0);
      checkOutput("abort_err", 64'(err), 64'h0);
      repeat (15) @(negedge clock);
      checkOutput("abort_stays_idle", 64'(busy), 64'h0);

      // Reset in the middle of the fetch
      applyStimulus(3'b111, 2'd0);
      repeat (2) @(negedge clock);
      checkOutput("fetch_busy", 64'(busy), 64'h1);
      checkOutput("fetch_rd_addr", 64'(mem_rd_addr), 64'd2);
      reset = 1'b1;
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'h0);
      checkOutput("midrst_rd_addr", 64'(mem_rd_addr), 64'h0);
      checkOutput("midrst_init_vals", 64'(|init_val_flat), 64'h0);
      checkOutput("midrst_unit_start", 64'(unit_start), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      checkOutput("midrst_stays_idle", 64'(busy), 64'h0);
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
